// File: rtl/arbiter_puf_array_pkg.sv
// Shared sizing defaults and controller state type for the arbiter PUF evaluator.
package arbiter_puf_array_pkg;
    localparam int C_LENGTH_DEF = 64;
    localparam int N_CH_DEF     = 8;
    localparam int N_VOTE_DEF   = 15;
    localparam int T_RESET_DEF  = 2;
    localparam int T_SETTLE_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_SAMPLE,
        ST_DONE
    } state_t;
endpackage

// File: rtl/arbiter_puf.sv
// Behavioural stand-in for the hard arbiter cell: the winner is a fixed
// function of the challenge while the race pulse is high, low otherwise.
module arbiter_puf #(
    parameter int C_LENGTH = 64
) (
    input  logic                race,
    input  logic [C_LENGTH-1:0] challenge,
    output logic                response
);
    assign response = race & (^challenge);
endmodule

// File: rtl/arbiter_puf_array_vote_acc.sv
// Per-channel vote accumulator: synchronises the asynchronous arbiter
// decision into the clock domain, counts ones and derives majority/unanimity.
module puf_vote_acc #(
    parameter int N_VOTE = 15
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic clear,
    input  logic sample,
    input  logic arb_in,
    output logic majority,
    output logic unstable
);
    localparam int CW = $clog2(N_VOTE + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // At most N_VOTE samples land between clears, so the count cannot wrap.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= arb_in;
            sync_b <= sync_a;
            if (clear) begin
                cnt <= '0;
            end else if (sample && sync_b) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign majority = (cnt > CW'(N_VOTE / 2));
    assign unstable = (cnt != '0) && (cnt != CW'(N_VOTE));
endmodule

// File: rtl/arbiter_puf_array.sv
// Multi-channel arbiter PUF evaluator: repeats each race N_VOTE times and
// returns a majority-voted response word with per-channel stability flags.
module arbiter_puf_array
    import arbiter_puf_array_pkg::*;
#(
    parameter int C_LENGTH = C_LENGTH_DEF,
    parameter int N_CH     = N_CH_DEF,
    parameter int N_VOTE   = N_VOTE_DEF,
    parameter int T_RESET  = T_RESET_DEF,
    parameter int T_SETTLE = T_SETTLE_DEF
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic [C_LENGTH-1:0] ichallenge,
    input  logic                ivalid,
    output logic                oready,
    output logic [N_CH-1:0]     oresponse,
    output logic [N_CH-1:0]     ounstable,
    output logic                ovalid,
    input  logic                iready,
    output logic                obusy
);
    localparam int CW   = $clog2(N_VOTE + 1);
    localparam int TMAX = (T_RESET > T_SETTLE) ? T_RESET : T_SETTLE;
    localparam int TW   = $clog2(TMAX + 1);

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       tmr;
    logic [TW-1:0]       tmr_nxt;
    logic [CW-1:0]       vote_idx;
    logic [C_LENGTH-1:0] chal_q;
    logic                race_pulse;
    logic                acc_clear;
    logic                acc_sample;
    logic [C_LENGTH-1:0] chan_chal [N_CH];
    logic [N_CH-1:0]     arb_out;
    logic [N_CH-1:0]     maj;
    logic [N_CH-1:0]     unst;

    always_comb begin
        state_nxt  = state;
        tmr_nxt    = tmr;
        acc_clear  = 1'b0;
        acc_sample = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ivalid) begin
                    state_nxt = ST_ARM;
                    tmr_nxt   = '0;
                    acc_clear = 1'b1;
                end
            end
            ST_ARM: begin
                if (tmr == TW'(T_RESET - 1)) begin
                    state_nxt = ST_FIRE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            ST_FIRE: begin
                if (tmr == TW'(T_SETTLE - 1)) begin
                    state_nxt = ST_SAMPLE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + TW'(1);
                end
            end
            ST_SAMPLE: begin
                acc_sample = 1'b1;
                tmr_nxt    = '0;
                state_nxt  = (vote_idx == CW'(N_VOTE - 1)) ? ST_DONE : ST_ARM;
            end
            ST_DONE: begin
                if (ovalid && iready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The race pulse is registered from the next state so it is glitch-free
    // and high exactly while the controller sits in FIRE or SAMPLE.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            vote_idx   <= '0;
            chal_q     <= '0;
            race_pulse <= 1'b0;
            ovalid     <= 1'b0;
            oresponse  <= '0;
            ounstable  <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            race_pulse <= (state_nxt == ST_FIRE) || (state_nxt == ST_SAMPLE);
            if (acc_clear) begin
                chal_q   <= ichallenge;
                vote_idx <= '0;
            end else if (acc_sample) begin
                vote_idx <= vote_idx + CW'(1);
            end
            if ((state == ST_DONE) && !ovalid) begin
                ovalid    <= 1'b1;
                oresponse <= maj;
                ounstable <= unst;
            end else if (ovalid && iready) begin
                ovalid <= 1'b0;
            end
        end
    end

    assign oready = (state == ST_IDLE);
    assign obusy  = (state == ST_ARM) || (state == ST_FIRE) || (state == ST_SAMPLE);

    // Each channel races the latched challenge rotated left by its index.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam int R = k % C_LENGTH;

        assign chan_chal[k] = (chal_q << R) | (chal_q >> (C_LENGTH - R));

        arbiter_puf #(
            .C_LENGTH(C_LENGTH)
        ) u_puf (
            .race     (race_pulse),
            .challenge(chan_chal[k]),
            .response (arb_out[k])
        );

        puf_vote_acc #(
            .N_VOTE(N_VOTE)
        ) u_acc (
            .iclk    (iclk),
            .irst_n  (irst_n),
            .clear   (acc_clear),
            .sample  (acc_sample),
            .arb_in  (arb_out[k]),
            .majority(maj[k]),
            .unstable(unst[k])
        );
    end
endmodule
